// File: rtl/eth_pixel_pkg.sv
// Shared definitions for the Ethernet video-line receiver.
// Contents: receive FSM state type, preamble/SFD byte values, header and
// line-index lengths, the broadcast MAC address, and a helper that extracts
// one MSB-first byte from a 48-bit MAC address.
package eth_pixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_LINEIDX,
        ST_PAYLOAD,
        ST_DRAIN
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned HDR_LEN       = 14;
    localparam int unsigned IDX_LEN       = 2;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    // Byte idx (0 = first on the wire) of a MAC address; idx > 5 yields 0.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] w_sh;
        w_sh = mac << (8 * idx);
        return w_sh[47:40];
    endfunction

endpackage

// File: rtl/eth_pixel_rx_hdr_match.sv
// eth_hdr_match: compares the 14-byte Ethernet header against the accepted
// destination MAC (unicast or broadcast) and the accepted EtherType.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_byte          header byte on the wire
//   i_byte_cnt      position of i_byte within the header (0..13)
//   i_en            i_byte is a valid header byte this cycle
//   o_mismatch      sticky mismatch, including the current byte
module eth_hdr_match
    import eth_pixel_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_byte,
    input  logic [3:0] i_byte_cnt,
    input  logic       i_en,
    output logic       o_mismatch
);

    logic r_mac_mis;
    logic r_bc_mis;
    logic r_et_mis;

    logic w_first;
    logic w_dst;
    logic w_mac_ne;
    logic w_bc_ne;
    logic w_et_ne;
    logic w_mac_acc;
    logic w_bc_acc;
    logic w_et_acc;

    assign w_first  = (i_byte_cnt == 4'd0);
    assign w_dst    = (i_byte_cnt < 4'd6);
    assign w_mac_ne = w_dst && (i_byte != mac_byte(MAC_ADDR, i_byte_cnt[2:0]));
    assign w_bc_ne  = w_dst && (i_byte != mac_byte(BCAST_MAC, i_byte_cnt[2:0]));
    // EtherType occupies the last two header bytes, big-endian.
    assign w_et_ne  = ((i_byte_cnt == 4'(HDR_LEN - 2)) && (i_byte != ETHERTYPE[15:8])) ||
                      ((i_byte_cnt == 4'(HDR_LEN - 1)) && (i_byte != ETHERTYPE[7:0]));

    // Byte 0 starts a fresh comparison, so the sticky history is ignored there.
    assign w_mac_acc = (r_mac_mis && !w_first) || w_mac_ne;
    assign w_bc_acc  = (r_bc_mis  && !w_first) || w_bc_ne;
    assign w_et_acc  = (r_et_mis  && !w_first) || w_et_ne;

    // Destination fails only if it matches neither unicast nor broadcast.
    assign o_mismatch = (w_mac_acc && w_bc_acc) || w_et_acc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mac_mis <= 1'b0;
            r_bc_mis  <= 1'b0;
            r_et_mis  <= 1'b0;
        end else if (i_en) begin
            r_mac_mis <= w_mac_acc;
            r_bc_mis  <= w_bc_acc;
            r_et_mis  <= w_et_acc;
        end
    end

endmodule

// File: rtl/eth_pixel_rx.sv
// eth_pixel_rx: GMII receive-side filter for frames carrying one video line.
// Accepts frames addressed to MAC_ADDR or broadcast with EtherType ETHERTYPE,
// extracts a big-endian line index and streams LINE_BYTES pixel bytes.
// Ports:
//   dclk, xrst            receive clock, synchronous active-low reset
//   rxd, rx_dv            GMII byte and data-valid
//   data_out, data_en     registered pixel byte stream
//   line_start, line_idx  start-of-line pulse and held line number
//   line_done             pulse with the final pixel byte
//   err, drop_cnt         protocol-error pulse and saturating error count
module eth_pixel_rx
    import eth_pixel_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int unsigned LINE_BYTES = 960,
    parameter int unsigned MAX_LINES  = 180,
    parameter int unsigned DROP_W     = 16
) (
    input  logic        dclk,
    input  logic        xrst,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    output logic [7:0]  data_out,
    output logic        data_en,
    output logic        line_start,
    output logic [15:0] line_idx,
    output logic        line_done,
    output logic        err,
    output logic [15:0] drop_cnt
);

    localparam int unsigned PIX_W   = $clog2(LINE_BYTES);
    localparam logic [15:0] MAX_IDX = 16'(MAX_LINES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_pre_cnt;
    logic [3:0]          r_byte_cnt;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic [7:0]          r_idx_hi;
    logic [7:0]          r_data_out;
    logic                r_data_en;
    logic                r_line_start;
    logic [15:0]         r_line_idx;
    logic                r_line_done;
    logic                r_err;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_mismatch;
    logic [15:0]         w_idx;
    logic                w_hdr_last;
    logic                w_idx_last;
    logic                w_pix_last;
    logic                w_err;
    logic                w_line_start;
    logic                w_data_en;
    logic                w_line_done;

    eth_hdr_match #(
        .MAC_ADDR  (MAC_ADDR),
        .ETHERTYPE (ETHERTYPE)
    ) u_hdr_match (
        .i_clk      (dclk),
        .i_rst_n    (xrst),
        .i_byte     (rxd),
        .i_byte_cnt (r_byte_cnt),
        .i_en       ((r_state == ST_HEADER) && rx_dv),
        .o_mismatch (w_mismatch)
    );

    assign w_idx      = {r_idx_hi, rxd};
    assign w_hdr_last = (r_byte_cnt == 4'(HDR_LEN - 1));
    assign w_idx_last = (r_byte_cnt == 4'(IDX_LEN - 1));
    assign w_pix_last = (r_pix_cnt == PIX_W'(LINE_BYTES - 1));

    // State register, counters and registered outputs.
    always_ff @(posedge dclk) begin
        if (!xrst) begin
            r_state      <= ST_IDLE;
            r_pre_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_idx_hi     <= '0;
            r_data_out   <= '0;
            r_data_en    <= 1'b0;
            r_line_start <= 1'b0;
            r_line_idx   <= '0;
            r_line_done  <= 1'b0;
            r_err        <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_IDLE)
                r_pre_cnt <= 4'd1;
            else if (r_state == ST_PREAMBLE)
                r_pre_cnt <= r_pre_cnt + 4'd1;

            // byte_cnt restarts on every state change, so HEADER and LINEIDX share it.
            if ((w_state_nxt == r_state) &&
                ((r_state == ST_HEADER) || (r_state == ST_LINEIDX)))
                r_byte_cnt <= r_byte_cnt + 4'd1;
            else
                r_byte_cnt <= '0;

            if (w_data_en)
                r_pix_cnt <= r_pix_cnt + 1'b1;
            else if (r_state != ST_PAYLOAD)
                r_pix_cnt <= '0;

            if ((r_state == ST_LINEIDX) && (r_byte_cnt == 4'd0))
                r_idx_hi <= rxd;

            if (w_data_en)
                r_data_out <= rxd;
            if (w_line_start)
                r_line_idx <= w_idx;

            r_data_en    <= w_data_en;
            r_line_start <= w_line_start;
            r_line_done  <= w_line_done;
            r_err        <= w_err;

            if (w_err && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:
                if (rx_dv)
                    w_state_nxt = (rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DRAIN;
            ST_PREAMBLE:
                if (!rx_dv)
                    w_state_nxt = ST_IDLE;
                else if (rxd == PREAMBLE_BYTE)
                    w_state_nxt = (r_pre_cnt == 4'd7) ? ST_DRAIN : ST_PREAMBLE;
                else if (rxd == SFD_BYTE)
                    w_state_nxt = ST_HEADER;
                else
                    w_state_nxt = ST_DRAIN;
            ST_HEADER:
                if (!rx_dv)
                    w_state_nxt = ST_IDLE;
                else if (w_hdr_last)
                    w_state_nxt = w_mismatch ? ST_DRAIN : ST_LINEIDX;
            ST_LINEIDX:
                if (!rx_dv)
                    w_state_nxt = ST_IDLE;
                else if (w_idx_last)
                    w_state_nxt = (w_idx >= MAX_IDX) ? ST_DRAIN : ST_PAYLOAD;
            ST_PAYLOAD:
                if (!rx_dv)
                    w_state_nxt = ST_IDLE;
                else if (w_pix_last)
                    w_state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (!rx_dv)
                    w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; every error path leaves the frame, so one error per frame.
    always_comb begin
        w_err        = 1'b0;
        w_line_start = 1'b0;
        w_data_en    = 1'b0;
        w_line_done  = 1'b0;
        case (r_state)
            ST_IDLE:
                w_err = rx_dv && (rxd != PREAMBLE_BYTE);
            ST_PREAMBLE:
                w_err = !rx_dv ||
                        ((rxd == PREAMBLE_BYTE) && (r_pre_cnt == 4'd7)) ||
                        ((rxd != PREAMBLE_BYTE) && (rxd != SFD_BYTE));
            ST_HEADER:
                w_err = !rx_dv;
            ST_LINEIDX:
                if (!rx_dv)
                    w_err = 1'b1;
                else if (w_idx_last) begin
                    w_err        = (w_idx >= MAX_IDX);
                    w_line_start = (w_idx < MAX_IDX);
                end
            ST_PAYLOAD:
                if (!rx_dv)
                    w_err = 1'b1;
                else begin
                    w_data_en   = 1'b1;
                    w_line_done = w_pix_last;
                end
            default: ;
        endcase
    end

    assign data_out   = r_data_out;
    assign data_en    = r_data_en;
    assign line_start = r_line_start;
    assign line_idx   = r_line_idx;
    assign line_done  = r_line_done;
    assign err        = r_err;
    assign drop_cnt   = 16'(r_drop_cnt);

endmodule
